// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer DRAM writer.
package fb_pkg;

    localparam int FRAME_WORDS_DEF = 240000;
    localparam int PIX_W           = 16;
    localparam int BUS_W           = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fb_state_e;

endpackage

// File: rtl/word_fifo.sv
// Single-clock word FIFO; head is read straight from the storage registers so
// a pushed word is visible the cycle after its push.
module word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (pop_i && !push_i) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fb_dram_writer.sv
// Frame-buffer writer: packs RGB555 pixel pairs into 32-bit words and streams
// one frame of them to DRAM through an Avalon-MM write master.
module fb_dram_writer
    import fb_pkg::*;
#(
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BUS_W-1:0] write_to_addr,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic [BUS_W-1:0] master_address,
    output logic             master_write,
    output logic [BUS_W-1:0] master_writedata,
    output logic [3:0]       master_byteenable,
    input  logic             master_wait_request,
    output logic             busy,
    output logic             done
);

    localparam int WC_W = $clog2(FRAME_WORDS + 1);
    localparam int PC_W = $clog2(2 * FRAME_WORDS + 1);

    fb_state_e        state_q;
    logic [BUS_W-1:0] addr_q;
    logic [WC_W-1:0]  wcnt_q;
    logic [PC_W-1:0]  pcnt_q;
    logic [PIX_W-1:0] pack_q;

    logic             run;
    logic             accept;
    logic             push;
    logic             wr_ack;
    logic             last_ack;
    logic             fifo_clr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [BUS_W-1:0] fifo_head;

    assign run         = (state_q == ST_RUN);
    assign pixel_ready = run && !fifo_full && (pcnt_q < PC_W'(2 * FRAME_WORDS));
    assign accept      = pixel_valid && pixel_ready;
    // Odd-numbered pixel completes the pair; the word goes in on its accept.
    assign push        = accept && pcnt_q[0];
    assign fifo_clr    = !run && start;

    assign master_write      = run && !fifo_empty;
    assign master_writedata  = fifo_head;
    assign master_address    = addr_q;
    assign master_byteenable = 4'hF;
    assign wr_ack            = master_write && !master_wait_request;
    assign last_ack          = wr_ack && (wcnt_q == WC_W'(FRAME_WORDS - 1));
    assign done              = last_ack;
    assign busy              = run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            pcnt_q  <= '0;
            pack_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        addr_q  <= write_to_addr;
                        wcnt_q  <= '0;
                        pcnt_q  <= '0;
                        pack_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        pcnt_q <= pcnt_q + PC_W'(1);
                        if (!pcnt_q[0]) pack_q <= pixel_in;
                    end
                    if (wr_ack) begin
                        addr_q <= addr_q + 32'd4;
                        wcnt_q <= wcnt_q + WC_W'(1);
                    end
                    if (last_ack) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BUS_W)
    ) u_word_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (fifo_clr),
        .push_i  (push),
        .wdata_i ({pixel_in, pack_q}),
        .pop_i   (wr_ack),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_fb_dram_writer.sv
// Bench for fb_dram_writer: a 4-word frame instance for the main scenarios and
// a 12-word, 4-deep instance for FIFO back-pressure.
module tb_fb_dram_writer;

    localparam int FW     = 4;
    localparam int BFW    = 12;
    localparam int BDEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, pixel_valid, pixel_ready;
    logic [31:0] write_to_addr, master_address, master_writedata;
    logic [15:0] pixel_in;
    logic        master_write, master_wait_request, busy, done;
    logic [3:0]  master_byteenable;

    logic        b_start, b_valid, b_ready;
    logic [31:0] b_addr_in, b_address, b_writedata;
    logic [15:0] b_pixel_in;
    logic        b_write, b_wait, b_busy, b_done;
    logic [3:0]  b_byteenable;

    fb_dram_writer #(.FRAME_WORDS(FW), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .write_to_addr(write_to_addr),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .master_address(master_address), .master_write(master_write),
        .master_writedata(master_writedata), .master_byteenable(master_byteenable),
        .master_wait_request(master_wait_request), .busy(busy), .done(done)
    );

    fb_dram_writer #(.FRAME_WORDS(BFW), .FIFO_DEPTH(BDEPTH)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .write_to_addr(b_addr_in),
        .pixel_in(b_pixel_in), .pixel_valid(b_valid), .pixel_ready(b_ready),
        .master_address(b_address), .master_write(b_write),
        .master_writedata(b_writedata), .master_byteenable(b_byteenable),
        .master_wait_request(b_wait), .busy(b_busy), .done(b_done)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] pix[$];
    logic [31:0] got_addr[$], got_data[$];
    int          done_cnt, done_at;
    logic [15:0] b_pix[$];
    logic [31:0] b_got_addr[$], b_got_data[$];
    int          b_done_cnt;

    // Transfers are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (master_write && !master_wait_request) begin
            got_addr.push_back(master_address);
            got_data.push_back(master_writedata);
        end
        if (done) begin
            done_cnt++;
            done_at = got_addr.size();
        end
        if (b_write && !b_wait) begin
            b_got_addr.push_back(b_address);
            b_got_data.push_back(b_writedata);
        end
        if (b_done) b_done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_pixels(input int n, input bit incr);
        pix.delete();
        for (int i = 0; i < n; i++)
            pix.push_back(incr ? 16'(i + 1) : 16'($urandom_range(0, 32767)));
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        done_at  = -1;
    endtask

    task automatic start_frame(input logic [31:0] base);
        start = 1'b1;
        write_to_addr = base;
        tick();
        start = 1'b0;
        write_to_addr = $urandom;
    endtask

    task automatic feed(input int valid_pct);
        int idx = 0;
        int cyc = 0;
        while (idx < pix.size() && cyc < 2000) begin
            pixel_valid = ($urandom_range(0, 99) < valid_pct);
            pixel_in    = pix[idx];
            @(negedge clk);
            if (pixel_valid && pixel_ready) idx++;
            tick();
            cyc++;
        end
        pixel_valid = 1'b0;
        checks++;
        if (idx != pix.size()) begin
            failures++;
            $display("FAIL feed_timeout: accepted %0d pixels, required %0d", idx, pix.size());
        end
    endtask

    task automatic stall_until_done(input int pct);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            master_wait_request = ($urandom_range(0, 99) < pct);
            tick();
            cyc++;
        end
        master_wait_request = 1'b0;
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL done_timeout: done never pulsed within %0d cycles", cyc);
        end
    endtask

    task automatic check_frame(input string name, input logic [31:0] base);
        int nw = pix.size() / 2;
        logic [31:0] ea, ed;
        @(negedge clk);
        checks++;
        if (got_addr.size() != nw) begin
            failures++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, got_addr.size(), nw);
        end
        for (int k = 0; k < nw && k < got_addr.size(); k++) begin
            ea = base + 32'(4 * k);
            ed = {pix[2*k+1], pix[2*k]};
            checks++;
            if (got_addr[k] !== ea) begin
                failures++;
                $display("FAIL %s_addr[%0d]: got %h, required %h", name, k, got_addr[k], ea);
            end
            checks++;
            if (got_data[k] !== ed) begin
                failures++;
                $display("FAIL %s_data[%0d]: got %h, required %h", name, k, got_data[k], ed);
            end
        end
        checks++;
        if (done_cnt != 1 || done_at != nw) begin
            failures++;
            $display("FAIL %s_done: pulses %0d at write %0d, required 1 at %0d", name, done_cnt, done_at, nw);
        end
        checks++;
        if (busy !== 1'b0 || master_write !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_after: busy=%b write=%b, required 0 0", name, busy, master_write);
        end
        tick();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (master_write !== 1'b0 || master_address !== 32'h0 || master_writedata !== 32'h0 ||
            pixel_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s: write=%b addr=%h data=%h ready=%b busy=%b done=%b, required all zero",
                     name, master_write, master_address, master_writedata, pixel_ready, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_reset_outputs("reset_values");
        checks++;
        if (master_byteenable !== 4'hF) begin
            failures++;
            $display("FAIL reset_byteenable: got %h, required f", master_byteenable);
        end
        checks++;
        if (b_write !== 1'b0 || b_ready !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_big: write=%b ready=%b busy=%b, required 0 0 0", b_write, b_ready, b_busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (master_write !== 1'b0 || busy !== 1'b0 || pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_quiet: write=%b busy=%b ready=%b, required 0 0 0",
                     master_write, busy, pixel_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        new_pixels(2 * FW, 1'b1);
        start_frame(32'h1000);
        fork
            feed(100);
            stall_until_done(0);
        join
        check_frame("basic", 32'h1000);
        checks++;
        if (got_data.size() != 4 || got_data[0] !== 32'h00020001 || got_data[3] !== 32'h00080007 ||
            got_addr[3] !== 32'h100C) begin
            failures++;
            $display("FAIL basic_literal: %0d writes, first data %h, last %h@%h, required 00020001 and 00080007@0000100c",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 32'h0,
                     got_data.size() > 3 ? got_data[3] : 32'h0, got_addr.size() > 3 ? got_addr[3] : 32'h0);
        end
    endtask

    task automatic test_stall();
        int cyc = 0;
        logic [31:0] ed;
        new_pixels(2 * FW, 1'b0);
        ed = {pix[1], pix[0]};
        master_wait_request = 1'b1;
        start_frame(32'h3000);
        fork
            feed(100);
            begin
                @(negedge clk);
                while (!master_write && cyc < 50) begin
                    tick();
                    @(negedge clk);
                    cyc++;
                end
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (master_write !== 1'b1 || master_address !== 32'h3000 || master_writedata !== ed) begin
                        failures++;
                        $display("FAIL stall_hold[%0d]: write=%b addr=%h data=%h, required 1 00003000 %h",
                                 i, master_write, master_address, master_writedata, ed);
                    end
                    tick();
                    if (i < 4) @(negedge clk);
                end
                stall_until_done(0);
            end
        join
        check_frame("stall", 32'h3000);
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int cyc = 0;
        b_pix.delete();
        for (int i = 0; i < 2 * BFW; i++) b_pix.push_back(16'($urandom_range(0, 32767)));
        b_got_addr.delete();
        b_got_data.delete();
        b_done_cnt = 0;
        b_wait = 1'b1;
        b_start = 1'b1;
        b_addr_in = 32'h8000;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1;
        while (cyc < 100 && acc < 2 * BFW) begin
            b_pixel_in = b_pix[acc];
            @(negedge clk);
            if (!b_ready) break;
            acc++;
            tick();
            cyc++;
        end
        checks++;
        if (acc != 2 * BDEPTH) begin
            failures++;
            $display("FAIL bp_accepted_before_full: got %0d, required %0d", acc, 2 * BDEPTH);
        end
        tick();
        b_valid = 1'b0;
        b_wait = 1'b0;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b0 || b_write !== 1'b1) begin
            failures++;
            $display("FAIL bp_still_full: ready=%b write=%b, required 0 1", b_ready, b_write);
        end
        tick();
        b_wait = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1 || b_got_addr.size() != 1) begin
            failures++;
            $display("FAIL bp_resume: ready=%b writes=%0d, required 1 1", b_ready, b_got_addr.size());
        end
        tick();
        cyc = 0;
        while (b_done_cnt == 0 && cyc < 1000) begin
            b_valid = (acc < 2 * BFW) && ($urandom_range(0, 99) < 80);
            b_pixel_in = (acc < 2 * BFW) ? b_pix[acc] : 16'h0;
            b_wait = ($urandom_range(0, 99) < 20);
            @(negedge clk);
            if (b_valid && b_ready) acc++;
            tick();
            cyc++;
        end
        b_valid = 1'b0;
        b_wait = 1'b0;
        checks++;
        if (acc != 2 * BFW || b_done_cnt != 1 || b_got_addr.size() != BFW) begin
            failures++;
            $display("FAIL bp_frame: pixels %0d writes %0d done %0d, required %0d %0d 1",
                     acc, b_got_addr.size(), b_done_cnt, 2 * BFW, BFW);
        end
        for (int k = 0; k < BFW && k < b_got_addr.size(); k++) begin
            checks++;
            if (b_got_addr[k] !== 32'h8000 + 32'(4 * k) || b_got_data[k] !== {b_pix[2*k+1], b_pix[2*k]}) begin
                failures++;
                $display("FAIL bp_word[%0d]: got %h@%h, required %h@%h", k, b_got_data[k], b_got_addr[k],
                         {b_pix[2*k+1], b_pix[2*k]}, 32'h8000 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_start_ignored();
        new_pixels(2 * FW, 1'b0);
        start_frame(32'h4000);
        fork
            feed(60);
            stall_until_done(30);
            begin
                repeat (3) tick();
                start = 1'b1;
                write_to_addr = 32'h9000;
                tick();
                start = 1'b0;
            end
        join
        check_frame("start_ignored", 32'h4000);
    endtask

    task automatic test_midframe_reset();
        int idx = 0;
        int cyc = 0;
        new_pixels(2 * FW, 1'b0);
        start_frame(32'h5000);
        while (got_addr.size() < 3 && cyc < 100) begin
            pixel_valid = (idx < pix.size());
            pixel_in = (idx < pix.size()) ? pix[idx] : 16'h0;
            @(negedge clk);
            if (pixel_valid && pixel_ready) idx++;
            tick();
            cyc++;
        end
        pixel_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset_immediate");
        @(negedge clk);
        check_reset_outputs("midreset_next_cycle");
        checks++;
        if (got_addr.size() != 3) begin
            failures++;
            $display("FAIL midreset_words: got %0d writes, required 3", got_addr.size());
        end
        tick();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (master_write !== 1'b0 || busy !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL midreset_no_resume: write=%b busy=%b done=%0d, required 0 0 0", master_write, busy, done_cnt);
        end
        tick();
        new_pixels(2 * FW, 1'b0);
        start_frame(32'h2000);
        fork
            feed(80);
            stall_until_done(20);
        join
        check_frame("after_reset", 32'h2000);
    endtask

    task automatic test_wrap();
        new_pixels(2 * FW, 1'b0);
        start_frame(32'hFFFF_FFF8);
        fork
            feed(70);
            stall_until_done(40);
        join
        check_frame("wrap", 32'hFFFF_FFF8);
        checks++;
        if (got_addr.size() != 4 || got_addr[0] !== 32'hFFFF_FFF8 || got_addr[1] !== 32'hFFFF_FFFC ||
            got_addr[2] !== 32'h0 || got_addr[3] !== 32'h4) begin
            failures++;
            $display("FAIL wrap_literal: %0d writes, addr[2]=%h addr[3]=%h, required 4 writes 00000000 00000004",
                     got_addr.size(), got_addr.size() > 2 ? got_addr[2] : 32'hx, got_addr.size() > 3 ? got_addr[3] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            new_pixels(2 * FW, 1'b0);
            start_frame(32'h6000 + 32'(f * 32'h100));
            fork
                feed(75);
                stall_until_done(25);
            join
            check_frame("back_to_back", 32'h6000 + 32'(f * 32'h100));
        end
    endtask

    initial begin
        start = 1'b0;
        write_to_addr = 32'h0;
        pixel_in = 16'h0;
        pixel_valid = 1'b0;
        master_wait_request = 1'b0;
        b_start = 1'b0;
        b_addr_in = 32'h0;
        b_pixel_in = 16'h0;
        b_valid = 1'b0;
        b_wait = 1'b0;
        done_cnt = 0;
        done_at = -1;
        b_done_cnt = 0;

        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_start_ignored();
        test_midframe_reset();
        test_wrap();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
